// File: rtl/sdr_dev_model.sv
// sdr_dev_model: RAM-side SDRAM responder.
// Decodes command pins, tracks per-bank open rows and the mode register,
// stores write bursts in an on-chip array and returns read bursts after the
// programmed CAS latency. Protocol violations pulse cmd_err and are counted.
module sdr_dev_model #(
    parameter int SDR_DW = 16,
    parameter int SDR_BW = 2,
    parameter int ROW_AW = 4,
    parameter int COL_AW = 8
) (
    input  logic              sdram_clk,
    input  logic              sdram_reset,
    input  logic              sdr_cke,
    input  logic              sdr_cs_n,
    input  logic              sdr_ras_n,
    input  logic              sdr_cas_n,
    input  logic              sdr_we_n,
    input  logic [1:0]        sdr_ba,
    input  logic [12:0]       sdr_addr,
    input  logic [SDR_BW-1:0] sdr_dqm,
    input  logic [SDR_DW-1:0] sdr_dq_in,
    output logic [SDR_DW-1:0] sdr_dq_out,
    output logic [SDR_BW-1:0] sdr_dq_oe,
    output logic              cmd_err,
    output logic [15:0]       err_cnt,
    output logic [1:0]        mode_cl,
    output logic [3:0]        mode_bl
);

    localparam int MEM_AW    = 2 + ROW_AW + COL_AW;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_BST = 4'b0110;

    // Control state (reset)
    logic [3:0]        bank_open;
    logic              ap_pend;
    logic [1:0]        ap_bank;
    logic              bst_act;
    logic              vld_p0;
    logic              cl2_p0;
    logic              vld_p1;

    // Datapath state (not reset; only meaningful when qualified by control)
    logic [ROW_AW-1:0] bank_row [4];
    logic              bst_rd;
    logic              bst_ap;
    logic [1:0]        bst_ba;
    logic [ROW_AW-1:0] bst_row;
    logic [COL_AW-1:0] bst_col;
    logic [3:0]        bst_bl;
    logic [2:0]        bst_k;
    logic [SDR_BW-1:0] dqm_p0;
    logic [SDR_BW-1:0] dqm_p1;
    logic [SDR_DW-1:0] rdata_p0;
    logic [SDR_DW-1:0] rdata_p1;
    logic [SDR_DW-1:0] mem [MEM_DEPTH];

    // Decode results
    logic [3:0]        cmd;
    logic [3:0]        ap_mask;
    logic [3:0]        lock_mask;
    logic [3:0]        open_eff;
    logic              mode_ok;
    logic [3:0]        new_bl;
    logic [1:0]        new_cl;
    logic              err_now;
    logic              acc_ok;
    logic              term;
    logic              last_beat;

    // Beat issue
    logic              iss_vld;
    logic              iss_rd;
    logic [1:0]        iss_ba;
    logic [ROW_AW-1:0] iss_row;
    logic [COL_AW-1:0] iss_col;
    logic [MEM_AW-1:0] iss_addr;

    // Row bits above ROW_AW and column bits above COL_AW carry no meaning here
    logic              unused_addr_bits;
    assign unused_addr_bits = ^sdr_addr;

    // Sequential wrap inside the BL-aligned block
    function automatic logic [COL_AW-1:0] burst_col(input logic [COL_AW-1:0] start,
                                                    input logic [2:0]        k,
                                                    input logic [3:0]        bl);
        logic [COL_AW-1:0] wrap;
        wrap = COL_AW'(bl - 4'd1);
        return (start & ~wrap) | ((start + COL_AW'(k)) & wrap);
    endfunction

    // Saturating violation counter step
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Command decode, legality checks and burst termination
    always_comb begin
        cmd       = {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n};
        ap_mask   = ap_pend ? (4'b0001 << ap_bank) : 4'b0000;
        lock_mask = (bst_act && bst_ap) ? (4'b0001 << bst_ba) : 4'b0000;
        open_eff  = bank_open & ~ap_mask;
        last_beat = bst_act && ({1'b0, bst_k} == bst_bl - 4'd1);

        mode_ok = 1'b1;
        new_bl  = 4'd1;
        new_cl  = 2'd3;
        case (sdr_addr[2:0])
            3'b000:  new_bl = 4'd1;
            3'b001:  new_bl = 4'd2;
            3'b010:  new_bl = 4'd4;
            3'b011:  new_bl = 4'd8;
            default: mode_ok = 1'b0;
        endcase
        case (sdr_addr[6:4])
            3'b010:  new_cl = 2'd2;
            3'b011:  new_cl = 2'd3;
            default: mode_ok = 1'b0;
        endcase
        if (sdr_addr[3])
            mode_ok = 1'b0;

        err_now = 1'b0;
        acc_ok  = 1'b0;
        term    = 1'b0;
        if (sdr_cke) begin
            case (cmd)
                CMD_LMR: err_now = (|open_eff) || !mode_ok;
                CMD_REF: err_now = |open_eff;
                CMD_ACT: err_now = open_eff[sdr_ba];
                CMD_WR, CMD_RD: begin
                    acc_ok  = open_eff[sdr_ba] && !lock_mask[sdr_ba];
                    err_now = !acc_ok;
                end
                default: ;
            endcase
            if (bst_act) begin
                if (acc_ok || cmd == CMD_BST)
                    term = 1'b1;
                if (cmd == CMD_PRE && (sdr_addr[10] || sdr_ba == bst_ba))
                    term = 1'b1;
            end
        end
    end

    // Select the beat accessed this edge: a new command's beat 0 or the next burst beat
    always_comb begin
        iss_vld = 1'b0;
        iss_rd  = bst_rd;
        iss_ba  = bst_ba;
        iss_row = bst_row;
        iss_col = burst_col(bst_col, bst_k, bst_bl);
        if (acc_ok) begin
            iss_vld = 1'b1;
            iss_rd  = (cmd == CMD_RD);
            iss_ba  = sdr_ba;
            iss_row = bank_row[sdr_ba];
            iss_col = sdr_addr[COL_AW-1:0];
        end else if (sdr_cke && bst_act && !term) begin
            iss_vld = 1'b1;
        end
        iss_addr = {iss_ba, iss_row, iss_col};
    end

    // Bank/mode/error state and burst activity
    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) begin
            bank_open <= '0;
            ap_pend   <= 1'b0;
            ap_bank   <= 2'd0;
            bst_act   <= 1'b0;
            mode_cl   <= 2'd3;
            mode_bl   <= 4'd1;
            cmd_err   <= 1'b0;
            err_cnt   <= 16'd0;
        end else if (sdr_cke) begin
            cmd_err <= err_now;
            if (err_now)
                err_cnt <= sat_inc(err_cnt);

            // Auto-precharge lands one edge after the final beat
            if (ap_pend)
                bank_open[ap_bank] <= 1'b0;
            // A cut-short auto-precharge burst closes its bank at the cut
            if (term && bst_ap)
                bank_open[bst_ba] <= 1'b0;

            if (!err_now) begin
                case (cmd)
                    CMD_LMR: begin
                        mode_bl <= new_bl;
                        mode_cl <= new_cl;
                    end
                    CMD_ACT: bank_open[sdr_ba] <= 1'b1;
                    CMD_PRE: begin
                        if (sdr_addr[10])
                            bank_open <= '0;
                        else
                            bank_open[sdr_ba] <= 1'b0;
                    end
                    default: ;
                endcase
            end

            ap_pend <= 1'b0;
            if (acc_ok) begin
                bst_act <= (mode_bl != 4'd1);
                if (mode_bl == 4'd1 && sdr_addr[10]) begin
                    ap_pend <= 1'b1;
                    ap_bank <= sdr_ba;
                end
            end else if (bst_act) begin
                if (term) begin
                    bst_act <= 1'b0;
                end else if (last_beat) begin
                    bst_act <= 1'b0;
                    if (bst_ap) begin
                        ap_pend <= 1'b1;
                        ap_bank <= bst_ba;
                    end
                end
            end
        end else begin
            cmd_err <= 1'b0;
        end
    end

    // Read pipeline valids and registered bus outputs
    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) begin
            vld_p0     <= 1'b0;
            cl2_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            sdr_dq_out <= '0;
            sdr_dq_oe  <= '0;
        end else if (sdr_cke) begin
            // p0: array read issued; p1: extra stage for CL3; then bus register
            vld_p0 <= iss_vld && iss_rd;
            cl2_p0 <= (mode_cl == 2'd2);
            vld_p1 <= vld_p0 && !cl2_p0;
            if (vld_p0 && cl2_p0) begin
                sdr_dq_out <= rdata_p0;
                sdr_dq_oe  <= ~dqm_p1;
            end else if (vld_p1) begin
                sdr_dq_out <= rdata_p1;
                sdr_dq_oe  <= ~dqm_p1;
            end else begin
                sdr_dq_out <= '0;
                sdr_dq_oe  <= '0;
            end
        end
    end

    // Datapath registers: row latches, burst descriptor, dqm history, read data
    always_ff @(posedge sdram_clk) begin
        if (sdr_cke) begin
            dqm_p0   <= sdr_dqm;
            dqm_p1   <= dqm_p0;
            rdata_p1 <= rdata_p0;
            if (iss_vld && iss_rd)
                rdata_p0 <= mem[iss_addr];
            if (!err_now && cmd == CMD_ACT)
                bank_row[sdr_ba] <= sdr_addr[ROW_AW-1:0];
            if (acc_ok) begin
                bst_rd  <= (cmd == CMD_RD);
                bst_ap  <= sdr_addr[10];
                bst_ba  <= sdr_ba;
                bst_row <= bank_row[sdr_ba];
                bst_col <= sdr_addr[COL_AW-1:0];
                bst_bl  <= mode_bl;
                bst_k   <= 3'd1;
            end else if (bst_act && !term) begin
                bst_k <= bst_k + 3'd1;
            end
        end
    end

    // Storage array with per-byte write masking
    always_ff @(posedge sdram_clk) begin
        if (sdr_cke && iss_vld && !iss_rd) begin
            for (int b = 0; b < SDR_BW; b++) begin
                if (!sdr_dqm[b])
                    mem[iss_addr][b*8 +: 8] <= sdr_dq_in[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sdr_dev_model.sv
// Directed bench for sdr_dev_model: mode register, masked writes, CL2/CL3
// reads with wrap, burst stop, auto-precharge, error counting, cke freeze
// and reset mid-burst.
module tb_sdr_dev_model;

    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] BST = 4'b0110;
    localparam logic [3:0] NOP = 4'b0111;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke;
    logic        cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [1:0]  dqm;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic [1:0]  dq_oe;
    logic        cmd_err;
    logic [15:0] err_cnt;
    logic [1:0]  mode_cl;
    logic [3:0]  mode_bl;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sdr_dev_model dut (
        .sdram_clk   (clk),
        .sdram_reset (rst),
        .sdr_cke     (cke),
        .sdr_cs_n    (cs_n),
        .sdr_ras_n   (ras_n),
        .sdr_cas_n   (cas_n),
        .sdr_we_n    (we_n),
        .sdr_ba      (ba),
        .sdr_addr    (addr),
        .sdr_dqm     (dqm),
        .sdr_dq_in   (dq_in),
        .sdr_dq_out  (dq_out),
        .sdr_dq_oe   (dq_oe),
        .cmd_err     (cmd_err),
        .err_cnt     (err_cnt),
        .mode_cl     (mode_cl),
        .mode_bl     (mode_bl)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one command cycle, step past the edge, leave outputs settled
    task automatic cyc(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                       input logic [1:0] m, input logic [15:0] d);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba    = b;
        addr  = a;
        dqm   = m;
        dq_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        cyc(NOP, 2'd0, 13'h000, 2'b00, 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cke = 1'b1;
        nop();
        nop();
        rst = 1'b0;
        chk("rst_cl", 16'(mode_cl), 16'd3);
        chk("rst_bl", 16'(mode_bl), 16'd1);
        chk("rst_out", dq_out, 16'h0000);
        chk("rst_oe", 16'(dq_oe), 16'd0);
        chk("rst_err", 16'(cmd_err), 16'd0);
        chk("rst_cnt", err_cnt, 16'd0);

        // Mode register: legal CL3/BL4, then interleaved code rejected
        cyc(LMR, 2'd0, 13'h032, 2'b00, 16'h0000);
        chk("lmr_cl3", 16'(mode_cl), 16'd3);
        chk("lmr_bl4", 16'(mode_bl), 16'd4);
        chk("lmr_ok_err", 16'(cmd_err), 16'd0);
        cyc(LMR, 2'd0, 13'h0F8, 2'b00, 16'h0000);
        chk("lmr_bad_err", 16'(cmd_err), 16'd1);
        chk("lmr_bad_cnt", err_cnt, 16'd1);
        chk("lmr_bad_bl", 16'(mode_bl), 16'd4);
        chk("lmr_bad_cl", 16'(mode_cl), 16'd3);
        nop();
        chk("err_pulse_end", 16'(cmd_err), 16'd0);

        // Masked write over prefilled data, wrap 12,13,10,11
        cyc(ACT, 2'd1, 13'h005, 2'b00, 16'h0000);
        cyc(WR,  2'd1, 13'h012, 2'b00, 16'hA0A0);
        cyc(NOP, 2'd0, 13'h000, 2'b00, 16'hA1A1);
        cyc(NOP, 2'd0, 13'h000, 2'b00, 16'hA2A2);
        cyc(NOP, 2'd0, 13'h000, 2'b00, 16'hA3A3);
        cyc(WR,  2'd1, 13'h012, 2'b00, 16'h1111);
        cyc(NOP, 2'd0, 13'h000, 2'b00, 16'h2222);
        cyc(NOP, 2'd0, 13'h000, 2'b01, 16'h3333);
        cyc(NOP, 2'd0, 13'h000, 2'b00, 16'h4444);

        // CL3 BL4 read; dqm=01 on E0+2 masks oe[0] of beat 2
        cyc(RD, 2'd1, 13'h012, 2'b00, 16'h0000);
        chk("cl3_e0_oe", 16'(dq_oe), 16'd0);
        nop();
        chk("cl3_e1_oe", 16'(dq_oe), 16'd0);
        cyc(NOP, 2'd0, 13'h000, 2'b01, 16'h0000);
        chk("cl3_b0_d", dq_out, 16'h1111);
        chk("cl3_b0_oe", 16'(dq_oe), 16'd3);
        nop();
        chk("cl3_b1_d", dq_out, 16'h2222);
        chk("cl3_b1_oe", 16'(dq_oe), 16'd3);
        nop();
        chk("cl3_b2_d", dq_out, 16'h33A2);
        chk("cl3_b2_oe", 16'(dq_oe), 16'd2);
        nop();
        chk("cl3_b3_d", dq_out, 16'h4444);
        chk("cl3_b3_oe", 16'(dq_oe), 16'd3);
        nop();
        chk("cl3_end_oe", 16'(dq_oe), 16'd0);
        chk("cl3_end_d", dq_out, 16'h0000);

        // CL2 BL4 read from 0x0E wraps 0E,0F,0C,0D
        cyc(PRE, 2'd0, 13'h400, 2'b00, 16'h0000);
        cyc(LMR, 2'd0, 13'h022, 2'b00, 16'h0000);
        chk("lmr_cl2", 16'(mode_cl), 16'd2);
        cyc(ACT, 2'd1, 13'h005, 2'b00, 16'h0000);
        cyc(WR,  2'd1, 13'h00C, 2'b00, 16'h0C0C);
        cyc(NOP, 2'd0, 13'h000, 2'b00, 16'h0D0D);
        cyc(NOP, 2'd0, 13'h000, 2'b00, 16'h0E0E);
        cyc(NOP, 2'd0, 13'h000, 2'b00, 16'h0F0F);
        cyc(RD,  2'd1, 13'h00E, 2'b00, 16'h0000);
        chk("cl2_e0_oe", 16'(dq_oe), 16'd0);
        nop();
        chk("cl2_b0_d", dq_out, 16'h0E0E);
        chk("cl2_b0_oe", 16'(dq_oe), 16'd3);
        nop();
        chk("cl2_b1_d", dq_out, 16'h0F0F);
        nop();
        chk("cl2_b2_d", dq_out, 16'h0C0C);
        nop();
        chk("cl2_b3_d", dq_out, 16'h0D0D);
        nop();
        chk("cl2_end_oe", 16'(dq_oe), 16'd0);

        // CL3 BL8 read stopped by BST after beat 2
        cyc(PRE, 2'd0, 13'h400, 2'b00, 16'h0000);
        cyc(LMR, 2'd0, 13'h033, 2'b00, 16'h0000);
        chk("lmr_bl8", 16'(mode_bl), 16'd8);
        cyc(ACT, 2'd1, 13'h005, 2'b00, 16'h0000);
        cyc(RD,  2'd1, 13'h010, 2'b00, 16'h0000);
        nop();
        nop();
        chk("bst_b0_d", dq_out, 16'h33A2);
        chk("bst_b0_oe", 16'(dq_oe), 16'd3);
        cyc(BST, 2'd0, 13'h000, 2'b00, 16'h0000);
        chk("bst_b1_d", dq_out, 16'h4444);
        nop();
        chk("bst_b2_d", dq_out, 16'h1111);
        nop();
        chk("bst_drain_oe", 16'(dq_oe), 16'd0);
        chk("bst_drain_d", dq_out, 16'h0000);
        nop();
        chk("bst_idle_oe", 16'(dq_oe), 16'd0);

        // Auto-precharge read; ACT on the edge after the last beat is legal
        cyc(RD, 2'd1, 13'h410, 2'b00, 16'h0000);
        for (int i = 1; i <= 7; i++) begin
            nop();
            if (i == 2)
                chk("ap_b0_d", dq_out, 16'h33A2);
        end
        cyc(ACT, 2'd1, 13'h005, 2'b00, 16'h0000);
        chk("ap_act_err", 16'(cmd_err), 16'd0);
        chk("ap_act_cnt", err_cnt, 16'd1);
        nop();
        nop();
        nop();

        // Three violations in a row
        cyc(RD, 2'd2, 13'h010, 2'b00, 16'h0000);
        chk("rd_closed_err", 16'(cmd_err), 16'd1);
        chk("rd_closed_cnt", err_cnt, 16'd2);
        cyc(ACT, 2'd1, 13'h006, 2'b00, 16'h0000);
        chk("act_open_err", 16'(cmd_err), 16'd1);
        chk("act_open_cnt", err_cnt, 16'd3);
        cyc(REF, 2'd0, 13'h000, 2'b00, 16'h0000);
        chk("ref_open_err", 16'(cmd_err), 16'd1);
        chk("ref_open_cnt", err_cnt, 16'd4);
        chk("ref_open_oe", 16'(dq_oe), 16'd0);
        chk("ref_open_d", dq_out, 16'h0000);

        // Read row 5 still (rejected ACT left it), freeze with cke=0
        cyc(RD, 2'd1, 13'h012, 2'b00, 16'h0000);
        chk("frz_e0_err", 16'(cmd_err), 16'd0);
        nop();
        nop();
        chk("frz_b0_d", dq_out, 16'h1111);
        cke = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nop();
            chk("frz_hold_d", dq_out, 16'h1111);
            chk("frz_hold_oe", 16'(dq_oe), 16'd3);
        end
        cke = 1'b1;
        nop();
        chk("frz_resume_d", dq_out, 16'h2222);
        chk("frz_resume_oe", 16'(dq_oe), 16'd3);
        nop();

        // Reset mid-burst clears outputs immediately and closes banks
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_oe", 16'(dq_oe), 16'd0);
        chk("rstmid_d", dq_out, 16'h0000);
        chk("rstmid_bl", 16'(mode_bl), 16'd1);
        chk("rstmid_cnt", err_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(RD, 2'd1, 13'h012, 2'b00, 16'h0000);
        chk("rstmid_closed_err", 16'(cmd_err), 16'd1);
        chk("rstmid_closed_cnt", err_cnt, 16'd1);
        nop();
        chk("rstmid_closed_oe", 16'(dq_oe), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
